// File: rtl/mcdp_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, extend modes, mux selects, multiplier FSM states.
package mcdp_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    localparam logic [1:0] IMM_ZX8  = 2'b00;
    localparam logic [1:0] IMM_ZX12 = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_ZERO = 2'b11;

    localparam logic [1:0] SRCA_A      = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_ZERO   = 2'b11;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier: operands latched on start, XLEN RUN cycles then a one-cycle DONE.
// Start is only accepted in IDLE; there is no other flow control.
module mul_iter
    import mcdp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d  = MUL_RUN;
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                done    = 1'b1;
                state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign product = prod_q;

endmodule

// File: rtl/mc_datapath_p.sv
// Multicycle datapath (PC, IR, regfile, ALU, optional iterative multiplier); stage registers update one cycle after control.
// No backpressure: the controller sequences all enables and waits for MulDone on multiplies.
module mc_datapath_p
    import mcdp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData,
    output logic [31:0]     Instr,
    output logic [3:0]      ALUFlags,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic            IRWrite,
    input  logic            AdrSrc,
    input  logic [1:0]      RegSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ImmSrc,
    input  logic [2:0]      ALUControl,
    input  logic            MulStart,
    output logic            MulBusy,
    output logic            MulDone
);
    logic [XLEN-1:0] pc_q, pc_d, data_q, data_d, a_q, a_d, wd_q, wd_d, aluout_q, aluout_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rf_q [0:14];
    logic [3:0]      ra1, ra2, wa;
    logic [XLEN-1:0] rd1, rd2, ext_imm, src_a, src_b, b_op, alu_res, result, mul_prod;
    logic [XLEN:0]   sum;
    logic            is_sub, use_mul, carry, ovf, mul_busy, mul_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            aluout_q <= aluout_d;
        end
    end

    // Register file is not reset; R15 is virtual and maps to the Result bus.
    always_ff @(posedge clk) begin
        if (RegWrite && (wa != 4'hF)) begin
            rf_q[wa] <= result;
        end
    end

    assign ra1 = RegSrc[0] ? 4'hF : instr_q[19:16];
    assign ra2 = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];
    assign wa  = instr_q[15:12];
    assign rd1 = (ra1 == 4'hF) ? result : rf_q[ra1];
    assign rd2 = (ra2 == 4'hF) ? result : rf_q[ra2];

    always_comb begin
        pc_d    = PCWrite ? result : pc_q;
        instr_d = IRWrite ? ReadData[31:0] : instr_q;
        data_d  = ReadData;
        a_d     = rd1;
        wd_d    = rd2;
        if (mul_busy) begin
            aluout_d = aluout_q;
        end else if (mul_done) begin
            aluout_d = mul_prod;
        end else begin
            aluout_d = alu_res;
        end
    end

    always_comb begin
        case (ImmSrc)
            IMM_ZX8:  ext_imm = {{(XLEN-8){1'b0}}, instr_q[7:0]};
            IMM_ZX12: ext_imm = {{(XLEN-12){1'b0}}, instr_q[11:0]};
            IMM_BR:   ext_imm = {{(XLEN-26){instr_q[23]}}, instr_q[23:0], 2'b00};
            default:  ext_imm = '0;
        endcase
    end

    always_comb begin
        case (ALUSrcA)
            SRCA_A:      src_a = a_q;
            SRCA_PC:     src_a = pc_q;
            SRCA_ALUOUT: src_a = aluout_q;
            default:     src_a = '0;
        endcase
        case (ALUSrcB)
            SRCB_WD:   src_b = wd_q;
            SRCB_IMM:  src_b = ext_imm;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = '0;
        endcase
        case (ResultSrc)
            RES_ALUOUT: result = aluout_q;
            RES_DATA:   result = data_q;
            RES_ALU:    result = alu_res;
            default:    result = '0;
        endcase
    end

    // SUB is a + ~b + 1, so the adder carry-out is directly NOT borrow.
    assign is_sub  = (ALUControl == ALU_SUB);
    assign use_mul = MUL_EN && (ALUControl == ALU_MUL);
    assign b_op    = is_sub ? ~src_b : src_b;
    assign sum     = {1'b0, src_a} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};

    always_comb begin
        alu_res = sum[XLEN-1:0];
        carry   = sum[XLEN];
        ovf     = (src_a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
        if (ALUControl == ALU_AND) begin
            alu_res = src_a & src_b;
            carry   = 1'b0;
            ovf     = 1'b0;
        end else if (ALUControl == ALU_ORR) begin
            alu_res = src_a | src_b;
            carry   = 1'b0;
            ovf     = 1'b0;
        end else if (use_mul) begin
            alu_res = mul_prod;
            carry   = 1'b0;
            ovf     = 1'b0;
        end
    end

    assign ALUFlags = {alu_res[XLEN-1], (alu_res == '0), carry, ovf};

    if (MUL_EN) begin : g_mul
        mul_iter #(.XLEN(XLEN)) u_mul (
            .clk     (clk),
            .reset   (reset),
            .start   (MulStart),
            .src_a   (src_a),
            .src_b   (src_b),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_prod)
        );
    end else begin : g_no_mul
        assign mul_busy = 1'b0;
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    assign Adr       = AdrSrc ? result : pc_q;
    assign WriteData = wd_q;
    assign Instr     = instr_q;
    assign MulBusy   = mul_busy;
    assign MulDone   = mul_done;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Bench for mc_datapath_p: 32-bit and 64-bit instances share stimulus; ALU and multiply results go through a scoreboard queue.
module tb_mc_datapath_p;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ReadData;
    logic [63:0] ReadData64;
    logic        PCWrite, RegWrite, IRWrite, AdrSrc, MulStart;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    logic [31:0] Adr, WriteData, Instr;
    logic [3:0]  ALUFlags;
    logic        MulBusy, MulDone;
    logic [63:0] Adr64, WriteData64;
    logic [31:0] Instr64;
    logic [3:0]  ALUFlags64;
    logic        MulBusy64, MulDone64;

    int tests_run = 0;
    int tests_failed = 0;
    logic [35:0] sb [$];
    logic [31:0] rf_m [0:15];

    logic [31:0] t_a  [0:8] = '{32'h5, 32'h7FFFFFFF, 32'h3, 32'hFFFFFFFF, 32'h80000000,
                                32'hF0F01234, 32'hF0F01234, 32'h2, 32'h12345678};
    logic [31:0] t_b  [0:8] = '{32'h5, 32'h1, 32'h5, 32'h1, 32'h1,
                                32'h0FF0FFFF, 32'h0FF0FFFF, 32'h3, 32'h11111111};
    logic [2:0]  t_op [0:8] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001,
                                3'b010, 3'b011, 3'b101, 3'b111};
    logic [31:0] t_r  [0:8] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h7FFFFFFF,
                                32'h00F01234, 32'hFFF0FFFF, 32'h5, 32'h23456789};
    logic [3:0]  t_f  [0:8] = '{4'h6, 4'h9, 4'h8, 4'h6, 4'h3, 4'h0, 4'h8, 4'h0, 4'h0};

    assign ReadData64 = {32'h0, ReadData};

    always #5 clk = ~clk;

    mc_datapath_p #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
    );

    mc_datapath_p #(.XLEN(64), .MUL_EN(1'b1)) dut64 (
        .clk(clk), .reset(reset), .Adr(Adr64), .WriteData(WriteData64), .ReadData(ReadData64),
        .Instr(Instr64), .ALUFlags(ALUFlags64), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .MulBusy(MulBusy64), .MulDone(MulDone64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0; AdrSrc = 1'b0; MulStart = 1'b0;
        RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 2'b00;
        ALUControl = 3'b000; ReadData = 32'h0;
    endtask

    // Loads Rd into IR, parks the value in the Data register, then writes it back via Result=Data.
    task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
        ReadData = {16'h0, idx, 12'h0}; IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; ReadData = val;
        tick();
        ResultSrc = 2'b01; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; ResultSrc = 2'b00;
        if (idx != 4'hF) rf_m[idx] = val;
    endtask

    task automatic select_regs(input logic [3:0] rn, input logic [3:0] rm);
        RegSrc = 2'b00;
        ReadData = {12'h0, rn, 12'h0, rm}; IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (Adr !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", Adr); end
        tests_run++;
        if (Instr !== 32'h0) begin tests_failed++; $display("FAIL reset_ir: got %h want 0", Instr); end
        tests_run++;
        if (WriteData !== 32'h0) begin tests_failed++; $display("FAIL reset_wd: got %h want 0", WriteData); end
        tests_run++;
        if (MulBusy !== 1'b0 || MulDone !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mul: busy=%b done=%b want 0 0", MulBusy, MulDone);
        end
        tests_run++;
        if (ALUFlags !== 4'h4) begin tests_failed++; $display("FAIL reset_flags: got %b want 0100", ALUFlags); end
        tests_run++;
        if (Adr64 !== 64'h0) begin tests_failed++; $display("FAIL reset_pc64: got %h want 0", Adr64); end
        reset = 1'b0;
    endtask

    task automatic test_ir_load();
        ReadData = 32'hE2811005; IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; ReadData = 32'h0;
        tests_run++;
        if (Instr !== 32'hE2811005) begin tests_failed++; $display("FAIL ir_load: got %h want e2811005", Instr); end
        tests_run++;
        if (Adr !== 32'h0) begin tests_failed++; $display("FAIL ir_pc: got %h want 0", Adr); end
        tests_run++;
        if (Instr64 !== 32'hE2811005) begin tests_failed++; $display("FAIL ir_load64: got %h want e2811005", Instr64); end
    endtask

    task automatic test_pc_r15();
        idle_inputs();
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        tests_run++;
        if (Adr !== 32'h4) begin tests_failed++; $display("FAIL pc_inc: got %h want 4", Adr); end
        // R15 on RD1 carries Result = PC+4 into A
        RegSrc = 2'b01;
        tick();
        RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b11; AdrSrc = 1'b1;
        #1;
        tests_run++;
        if (Adr !== 32'h8) begin tests_failed++; $display("FAIL r15_read: got %h want 8", Adr); end
        AdrSrc = 1'b0;
        #1;
        tests_run++;
        if (Adr !== 32'h4) begin tests_failed++; $display("FAIL pc_hold: got %h want 4", Adr); end
        idle_inputs();
    endtask

    task automatic test_alu();
        logic [35:0] e;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            write_reg(4'd1, t_a[i]);
            write_reg(4'd2, t_b[i]);
            select_regs(4'd1, 4'd2);
            ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b10; AdrSrc = 1'b1;
            ALUControl = t_op[i];
            sb.push_back({t_f[i], t_r[i]});
            #1;
            e = sb.pop_front();
            tests_run++;
            if (Adr !== e[31:0] || ALUFlags !== e[35:32]) begin
                tests_failed++;
                $display("FAIL alu[%0d] op=%b: result=%h flags=%b, want result=%h flags=%b",
                         i, t_op[i], Adr, ALUFlags, e[31:0], e[35:32]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_extend();
        logic [31:0] w32 [0:3] = '{32'h000000FE, 32'h00000FFE, 32'hFFFFFFF8, 32'h0};
        logic [63:0] w64 [0:3] = '{64'hFE, 64'hFFE, 64'hFFFFFFFFFFFFFFF8, 64'h0};
        idle_inputs();
        ReadData = 32'h00FFFFFE; IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        ALUSrcA = 2'b11; ALUSrcB = 2'b01; ResultSrc = 2'b10; AdrSrc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ImmSrc = 2'(i);
            #1;
            tests_run++;
            if (Adr !== w32[i] || Adr64 !== w64[i]) begin
                tests_failed++;
                $display("FAIL extend[%0d]: got %h / %h want %h / %h", i, Adr, Adr64, w32[i], w64[i]);
            end
        end
        ReadData = 32'h00123456; IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0; ImmSrc = 2'b10;
        #1;
        tests_run++;
        if (Adr !== 32'h0048D158 || Adr64 !== 64'h0048D158) begin
            tests_failed++;
            $display("FAIL extend_pos: got %h / %h want 0048d158", Adr, Adr64);
        end
        idle_inputs();
    endtask

    task automatic test_mul();
        logic [35:0] e;
        int busy_cnt = 0;
        int done_cnt = 0;
        bit seen = 1'b0;
        idle_inputs();
        write_reg(4'd1, 32'd7);
        write_reg(4'd2, 32'd6);
        select_regs(4'd1, 4'd2);
        ALUControl = 3'b100; ResultSrc = 2'b00; AdrSrc = 1'b1; MulStart = 1'b1;
        sb.push_back({4'h0, rf_m[1] * rf_m[2]});
        tick();
        // Operand muxes move away during RUN; the product must not notice.
        MulStart = 1'b0; ALUSrcA = 2'b11; ALUSrcB = 2'b11;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (MulBusy) busy_cnt++;
            if (MulDone) begin done_cnt++; seen = 1'b1; end
            MulStart = (i == 5) || MulDone;
            tick();
        end
        MulStart = 1'b0;
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL mul_timeout: no MulDone within 80 cycles"); end
        tests_run++;
        if (busy_cnt != 32 || done_cnt != 1) begin
            tests_failed++; $display("FAIL mul_timing: busy=%0d done=%0d want 32 1", busy_cnt, done_cnt);
        end
        tests_run++;
        if (MulBusy !== 1'b0) begin tests_failed++; $display("FAIL mul_start_in_done: busy=%b want 0", MulBusy); end
        e = sb.pop_front();
        tests_run++;
        if (Adr !== e[31:0]) begin tests_failed++; $display("FAIL mul_result: got %h want %h", Adr, e[31:0]); end
        tick();
        tests_run++;
        if (MulDone !== 1'b0 || Adr !== e[31:0]) begin
            tests_failed++; $display("FAIL mul_after: done=%b aluout=%h want 0 %h", MulDone, Adr, e[31:0]);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        logic [35:0] e;
        int busy_cnt = 0;
        int done_cnt = 0;
        idle_inputs();
        select_regs(4'd1, 4'd2);
        ALUControl = 3'b100; ResultSrc = 2'b00; AdrSrc = 1'b1; MulStart = 1'b1;
        sb.push_back({4'h0, rf_m[1] * rf_m[2]});
        tick();
        for (int i = 0; i < 10; i++) begin
            if (MulBusy) busy_cnt++;
            MulStart = (i == 3);
            reset = (i == 9);
            tick();
        end
        reset = 1'b0; MulStart = 1'b0;
        e = sb.pop_front();  // aborted multiply never delivers
        tests_run++;
        if (busy_cnt != 10) begin tests_failed++; $display("FAIL abort_busy: got %0d want 10", busy_cnt); end
        tests_run++;
        if (MulBusy !== 1'b0 || MulDone !== 1'b0 || Adr !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b done=%b aluout=%h want 0 0 0 (dropped %h)", MulBusy, MulDone, Adr, e[31:0]);
        end
        tests_run++;
        if (Instr !== 32'h0) begin tests_failed++; $display("FAIL abort_ir: got %h want 0", Instr); end
        for (int i = 0; i < 40; i++) begin
            if (MulDone) done_cnt++;
            tick();
        end
        tests_run++;
        if (done_cnt != 0 || Adr !== 32'h0) begin
            tests_failed++; $display("FAIL abort_nodone: done=%0d aluout=%h want 0 0", done_cnt, Adr);
        end
        idle_inputs();
        select_regs(4'd1, 4'd2);
        tests_run++;
        if (WriteData !== rf_m[2]) begin
            tests_failed++; $display("FAIL rf_keep: got %h want %h", WriteData, rf_m[2]);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_ir_load();
        test_pc_r15();
        test_alu();
        test_extend();
        test_mul();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
